// File: rtl/pool_module.sv
// ReLU + 2x2 stride-2 max pooling of a captured CHxIN_DIMxIN_DIM map, one window per cycle.
// Define POOL_RELU_EN to clamp negative elements to zero before comparison.
module pool_module #(
    parameter int unsigned DW      = 8,
    parameter int unsigned CH      = 3,
    parameter int unsigned IN_DIM  = 6,
    parameter int unsigned OUT_DIM = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_vld,
    input  logic [IN_DIM*IN_DIM*CH*DW-1:0]    conv_lin,
    output logic [OUT_DIM*OUT_DIM*CH*DW-1:0]  pool_lin,
    output logic                              out_vld,
    output logic                              busy
);

    localparam int unsigned IN_W  = IN_DIM*IN_DIM*CH*DW;
    localparam int unsigned OUT_W = OUT_DIM*OUT_DIM*CH*DW;
    localparam int unsigned NWIN  = OUT_DIM*OUT_DIM;
    localparam int unsigned WCW   = (NWIN > 1) ? $clog2(NWIN) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [WCW-1:0]       win_cnt_q, win_cnt_d;
    logic [IN_W-1:0]      in_buf_q, in_buf_d;
    logic [OUT_W-1:0]     work_q, work_d;
    logic [OUT_W-1:0]     pool_q, pool_d;

    function automatic logic [DW-1:0] elem(input logic [IN_W-1:0] b, input int unsigned ch,
                                           input int unsigned r, input int unsigned c);
        return b[((ch*IN_DIM*IN_DIM) + r*IN_DIM + c)*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] prep(input logic [DW-1:0] x);
`ifdef POOL_RELU_EN
        return x[DW-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return ($signed(a) >= $signed(b)) ? a : b;
    endfunction

    function automatic logic [DW-1:0] pool4(input logic [IN_W-1:0] b, input int unsigned ch,
                                            input int unsigned r, input int unsigned c);
        logic [DW-1:0] m01, m23;
        m01 = smax(prep(elem(b, ch, 2*r,   2*c)), prep(elem(b, ch, 2*r,   2*c+1)));
        m23 = smax(prep(elem(b, ch, 2*r+1, 2*c)), prep(elem(b, ch, 2*r+1, 2*c+1)));
        return smax(m01, m23);
    endfunction

    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        in_buf_d  = in_buf_q;
        work_d    = work_q;
        pool_d    = pool_q;
        case (state_q)
            IDLE: begin
                if (in_vld) begin
                    in_buf_d  = conv_lin;
                    win_cnt_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Window index is decoded against every constant so all slices stay static.
                for (int unsigned w = 0; w < NWIN; w++) begin
                    if (win_cnt_q == WCW'(w)) begin
                        for (int unsigned ch = 0; ch < CH; ch++) begin
                            work_d[(ch*NWIN + w)*DW +: DW] =
                                pool4(in_buf_q, ch, w / OUT_DIM, w % OUT_DIM);
                        end
                    end
                end
                if (win_cnt_q == WCW'(NWIN-1)) begin
                    win_cnt_d = '0;
                    state_d   = DONE;
                end else begin
                    win_cnt_d = win_cnt_q + WCW'(1);
                end
            end
            DONE: begin
                pool_d  = work_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_cnt_q <= '0;
            in_buf_q  <= '0;
            work_q    <= '0;
            pool_q    <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            in_buf_q  <= in_buf_d;
            work_q    <= work_d;
            pool_q    <= pool_d;
        end
    end

    assign pool_lin = pool_q;
    assign out_vld  = (state_q == DONE);
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_pool_module.sv
// Directed-vector bench for pool_module: table of maps with hand-derived pooled results,
// plus busy-drop, back-to-back and mid-run reset sequences.
module tb_pool_module;

    localparam int IW = 864;
    localparam int OW = 216;

    typedef struct {
        logic [IW-1:0] in_map;
        logic [OW-1:0] exp_map;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_vld = 1'b0;
    logic [IW-1:0] conv_lin = '0;
    logic [OW-1:0] pool_lin;
    logic          out_vld;
    logic          busy;

    int n_vec  = 0;
    int n_fail = 0;

    vec_t vecs[3];

    pool_module #(.DW(8), .CH(3), .IN_DIM(6), .OUT_DIM(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (in_vld),
        .conv_lin (conv_lin),
        .pool_lin (pool_lin),
        .out_vld  (out_vld),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [IW-1:0] put_in(input logic [IW-1:0] m, input int ch, input int r,
                                             input int c, input logic [7:0] v);
        m[((ch*36) + r*6 + c)*8 +: 8] = v;
        return m;
    endfunction

    function automatic logic [OW-1:0] put_out(input logic [OW-1:0] m, input int ch, input int r,
                                              input int c, input logic [7:0] v);
        m[((ch*9) + r*3 + c)*8 +: 8] = v;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk_map(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Map accepted at T; out_vld expected only at T+10, result visible from T+11.
    task automatic run_map(input int id, input logic [IW-1:0] m, input logic [OW-1:0] e);
        conv_lin = m;
        in_vld   = 1'b1;
        step();
        in_vld   = 1'b0;
        conv_lin = ~m;
        for (int k = 1; k <= 11; k++) begin
            chk_bit($sformatf("v%0d out_vld T+%0d", id, k), out_vld, k == 10);
            chk_bit($sformatf("v%0d busy T+%0d", id, k), busy, k <= 10);
            if (k == 11) chk_map($sformatf("v%0d pool_lin", id), pool_lin, e);
            else step();
        end
    endtask

    initial begin
        logic [IW-1:0] mi;
        logic [OW-1:0] me;
        logic [7:0]    neg_fill;

`ifdef POOL_RELU_EN
        neg_fill = 8'h00;
`else
        neg_fill = 8'hFD;
`endif

        // Vector 0: basic pool
        mi = '0;
        me = '0;
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 6; c++) begin
                mi = put_in(mi, 0, r, c, 8'h05);
                mi = put_in(mi, 1, r, c, 8'h01);
                mi = put_in(mi, 2, r, c, 8'(r*6 + c));
            end
        mi = put_in(mi, 0, 0, 1, 8'h14);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                me = put_out(me, 0, r, c, 8'h05);
                me = put_out(me, 1, r, c, 8'h01);
                me = put_out(me, 2, r, c, 8'((2*r + 1)*6 + 2*c + 1));
            end
        me = put_out(me, 0, 0, 0, 8'h14);
        vecs[0].in_map  = mi;
        vecs[0].exp_map = me;

        // Vector 1: negatives, one positive in the bottom-right corner of ch1
        mi = '0;
        me = '0;
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 6; r++)
                for (int c = 0; c < 6; c++) mi = put_in(mi, ch, r, c, 8'hFD);
        mi = put_in(mi, 1, 5, 5, 8'h7F);
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) me = put_out(me, ch, r, c, neg_fill);
        me = put_out(me, 1, 2, 2, 8'h7F);
        vecs[1].in_map  = mi;
        vecs[1].exp_map = me;

        // Vector 2: signed compare window {0x80,0x7F,0x00,0xFF} in ch0 (0,0)
        mi = '0;
        mi = put_in(mi, 0, 0, 0, 8'h80);
        mi = put_in(mi, 0, 0, 1, 8'h7F);
        mi = put_in(mi, 0, 1, 0, 8'h00);
        mi = put_in(mi, 0, 1, 1, 8'hFF);
        me = '0;
        me = put_out(me, 0, 0, 0, 8'h7F);
        vecs[2].in_map  = mi;
        vecs[2].exp_map = me;

        // Reset state
        rst_n = 1'b0;
        step();
        step();
        chk_bit("reset out_vld", out_vld, 1'b0);
        chk_bit("reset busy", busy, 1'b0);
        chk_map("reset pool_lin", pool_lin, '0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 3; i++) begin
            run_map(i, vecs[i].in_map, vecs[i].exp_map);
            step();
        end

        // Busy drop: extra pulses at T+4 and T+10 (DONE cycle) are ignored
        conv_lin = vecs[0].in_map;
        in_vld   = 1'b1;
        step();
        in_vld   = 1'b0;
        conv_lin = vecs[1].in_map;
        for (int k = 1; k <= 22; k++) begin
            in_vld = (k == 4) || (k == 10);
            chk_bit($sformatf("drop out_vld T+%0d", k), out_vld, k == 10);
            chk_bit($sformatf("drop busy T+%0d", k), busy, k <= 10);
            if (k == 11 || k == 22) chk_map($sformatf("drop pool_lin T+%0d", k), pool_lin, vecs[0].exp_map);
            step();
        end
        in_vld = 1'b0;

        // Back-to-back: A at T, B at T+11
        conv_lin = vecs[0].in_map;
        in_vld   = 1'b1;
        step();
        in_vld   = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            in_vld   = (k == 11);
            conv_lin = (k == 11) ? vecs[2].in_map : vecs[1].in_map;
            chk_bit($sformatf("b2b out_vld T+%0d", k), out_vld, (k == 10) || (k == 21));
            if (k == 11 || k == 21) chk_map($sformatf("b2b pool_lin A T+%0d", k), pool_lin, vecs[0].exp_map);
            if (k == 22) chk_map("b2b pool_lin B", pool_lin, vecs[2].exp_map);
            if (k < 22) step();
        end
        in_vld = 1'b0;
        step();

        // Reset mid-run: reset at T+5..T+6, new map at T+9
        conv_lin = vecs[0].in_map;
        in_vld   = 1'b1;
        step();
        in_vld   = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            rst_n    = !((k == 5) || (k == 6));
            in_vld   = (k == 9);
            conv_lin = (k == 9) ? vecs[1].in_map : vecs[2].in_map;
            #1;
            chk_bit($sformatf("rst out_vld T+%0d", k), out_vld, k == 19);
            if (k == 5 || k == 8) chk_map($sformatf("rst pool_lin T+%0d", k), pool_lin, '0);
            if (k == 7 || k == 9) chk_bit($sformatf("rst busy T+%0d", k), busy, 1'b0);
            if (k == 12) chk_bit("rst busy T+12", busy, 1'b1);
            if (k == 20) chk_map("rst pool_lin B", pool_lin, vecs[1].exp_map);
            step();
        end
        in_vld = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pool_module.md
Name: pool_module

Overview:
- Downstream stage of the slow convolution block.
- Captures one 6x6x3 signed 8-bit feature map on the conv out_vld pulse.
- Applies ReLU, then 2x2 stride-2 max pooling, serially, one output window (all 3 channels in parallel) per cycle.
- Presents a 3x3x3 pooled map with a one-cycle out_vld pulse. Feeds the next layer.

Parameters:
- DW, 8, element width (signed two's complement).
- CH, 3, channel count.
- IN_DIM, 6, input rows/cols.
- OUT_DIM, 3, output rows/cols (IN_DIM/2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_vld  input  1  one-cycle pulse; conv_lin valid this cycle.
- conv_lin  input  IN_DIM*IN_DIM*CH*DW  feature map; element (ch,r,c) at bits [((ch*36)+r*6+c)*8 +: 8].
- pool_lin  output  OUT_DIM*OUT_DIM*CH*DW  pooled map; element (ch,r,c) at bits [((ch*9)+r*3+c)*8 +: 8].
- out_vld  output  1  one-cycle pulse; pool_lin newly updated.
- busy  output  1  high while a map is being processed (state != IDLE).

Behaviour:
- Reset (async, rst_n low): state=IDLE, window counter=0, input buffer=0, working buffer=0, pool_lin=0, out_vld=0, busy=0.
- FSM states:
  - IDLE: on in_vld=1, latch conv_lin into the input buffer, clear win_cnt, go to RUN.
  - RUN: each cycle, process window win_cnt (0..8, r=win_cnt/3, c=win_cnt%3).
    - Covers input rows 2r..2r+1 and cols 2c..2c+1.
    - For each channel, write max of the 4 (ReLU-applied) elements into working buffer slot (ch,r,c).
    - win_cnt increments each cycle; at win_cnt==8 go to DONE and wrap win_cnt to 0.
  - DONE: copy the working buffer to the pool_lin register; out_vld=1 for this cycle only; go to IDLE.
- Latency:
  - in_vld in cycle T → RUN in cycles T+1..T+9.
  - DONE/out_vld in cycle T+10.
  - pool_lin updates at the edge ending T+10 and is held stable until the next DONE.
  - Accepted-input throughput: one map per 11 cycles.
- busy=1 during RUN and DONE.
- in_vld while busy: input ignored (dropped), no state change.
  - Upstream must not pulse in_vld while busy.
  - in_vld in the DONE cycle is also dropped.
- Arithmetic:
  - Signed 8-bit comparison; no widening, no saturation needed.
  - Max of equal values returns that value.
  - ReLU maps any value with MSB=1 to 0.
  - 0x80 (-128) treated as negative.
- Reset mid-operation: immediately returns to IDLE with all registers cleared; no out_vld for the aborted map.
- conv_lin is sampled only in the in_vld cycle; later changes do not affect the result.

Optional Feature:
- Macro: POOL_RELU_EN.
- Defined: ReLU applied before comparison; all pool_lin elements are >=0.
- Undefined: raw signed max pooling; negative results pass through (e.g. window of all 0xFD yields 0xFD).
- Port list and timing are identical in both builds.

Test Plan:
- Basic pool:
  - Stimulus: ch0 all 0x05 except (ch0,r0,c1)=0x14; ch1 all 0x01; ch2 = r*6+c; in_vld pulse at T.
  - Response: out_vld only at T+10; pool ch0 (0,0)=0x14, all other ch0=0x05; ch1 all 0x01; ch2 (r,c) = (2r+1)*6+2c+1, e.g. (2,2)=0x23.
- Negatives:
  - Stimulus: all elements 0xFD except (ch1,r5,c5)=0x7F.
  - Response with POOL_RELU_EN: all 0x00 except ch1 (2,2)=0x7F.
  - Response without POOL_RELU_EN: all 0xFD except ch1 (2,2)=0x7F.
- Signed compare:
  - Stimulus: window {0x80,0x7F,0x00,0xFF}.
  - Response: 0x7F in both builds.
- Busy drop:
  - Stimulus: second in_vld with a different map at T+4 and at T+10.
  - Response: both dropped; exactly one out_vld; pool_lin reflects the first map; busy high T+1..T+10.
- Back-to-back:
  - Stimulus: maps A at T, B at T+11.
  - Response: out_vld at T+10 (A) and T+21 (B); pool_lin holds A between them.
- Reset mid-run:
  - Stimulus: rst_n low at T+5 for 2 cycles, then a new map at T+9.
  - Response: no out_vld for the first map; pool_lin=0 after reset; out_vld at T+19 with the second map's result.
